// File: rtl/design_28_driver_pkg.sv
// Shared types and default sizing for the design_28 request driver.
package design_28_driver_pkg;

    localparam int DEF_W       = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/design_28_driver_if.sv
// Upstream request / downstream response bundle of the design_28 driver.
interface design_28_driver_if
    import design_28_driver_pkg::*;
#(
    parameter int W = DEF_W
);

    // A transfer happens on any rising edge where valid && ready; a source keeps
    // valid and its payload steady until that edge, and ready never waits on valid.
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_y;
    logic         rsp_err;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_err
    );

endinterface

// File: rtl/design_28_req_fifo.sv
// Synchronous request FIFO; head entry is visible on rdata without a pop.
module design_28_req_fifo
    import design_28_driver_pkg::*;
#(
    parameter int DW    = 2 * DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DW-1:0]              wdata,
    input  logic                       pop,
    output logic [DW-1:0]              rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == NW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/design_28_driver.sv
// Queues operand pairs, runs them one at a time through an external compute
// block with a timeout, and returns results (or an error) in request order.
module design_28_driver
    import design_28_driver_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    design_28_driver_if.slave   bus,
    output logic                dut_start,
    output logic [W-1:0]        dut_a,
    output logic [W-1:0]        dut_b,
    input  logic [W-1:0]        dut_y,
    input  logic                dut_valid,
    output logic                busy,
    output state_t              fsm_state
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;
    logic            capture_ok;
    logic            capture_to;
    logic            fifo_full;
    logic            fifo_empty;
    logic [NW-1:0]   fifo_count;
    logic [NW-1:0]   count_next;
    logic [2*W-1:0]  fifo_head;
    logic            rsp_valid_q;
    logic [W-1:0]    rsp_y_q;
    logic            rsp_err_q;

    // Held low throughout reset so nothing is accepted before the FIFO is clean.
    assign bus.req_ready = rst_n && !fifo_full;
    assign push          = bus.req_valid && bus.req_ready;
    assign count_next    = fifo_count + NW'(push) - NW'(pop);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_err   = rsp_err_q;
    assign fsm_state     = state;

    design_28_req_fifo #(
        .DW    (2 * W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({bus.req_a, bus.req_b}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture_ok = 1'b0;
        capture_to = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // A result arriving on the last allowed cycle still counts as success.
                if (dut_valid) begin
                    capture_ok = 1'b1;
                    state_next = HOLD;
                end else if (cnt >= CNT_LAST) begin
                    capture_to = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            dut_a       <= '0;
            dut_b       <= '0;
            dut_start   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_err_q   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            dut_start   <= (state_next == ISSUE);
            rsp_valid_q <= (state_next == HOLD);
            busy        <= (state_next != IDLE) || (count_next != '0);
            if (pop) {dut_a, dut_b} <= fifo_head;
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT && cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
            if (capture_ok) begin
                rsp_y_q   <= dut_y;
                rsp_err_q <= 1'b0;
            end else if (capture_to) begin
                rsp_y_q   <= '0;
                rsp_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_design_28_driver.sv
// Directed bench for design_28_driver with a compute-block model and an in-order scoreboard.
module tb_design_28_driver;
    import design_28_driver_pkg::*;

    localparam int W       = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic         clk;
    logic         rst_n;
    logic         dut_start;
    logic [W-1:0] dut_a;
    logic [W-1:0] dut_b;
    logic [W-1:0] dut_y;
    logic         dut_valid;
    logic         busy;
    state_t       fsm_state;

    design_28_driver_if #(.W(W)) bus_if ();

    design_28_driver #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .dut_start (dut_start),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_y     (dut_y),
        .dut_valid (dut_valid),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // Expected response per accepted request: {err, y}
    logic [W:0]     exp_q[$];
    logic [2*W-1:0] iss_q[$];
    int             lat_q[$];

    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           rsp_cnt = 0;
    int           start_cnt = 0;
    int           last_start_cyc = -100;
    logic [W-1:0] last_y = '0;
    logic         last_err = 1'b0;
    bit           spur = 1'b0;
    int           cm_left = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_req(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                            output int waited);
        logic [W:0] sum;
        bus_if.req_valid = 1'b1;
        bus_if.req_a     = a;
        bus_if.req_b     = b;
        waited           = 0;
        @(negedge clk);
        while (!bus_if.req_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("req_accepted", bus_if.req_ready, 1);
        @(posedge clk);
        if (bus_if.req_ready) begin
            sum = {1'b0, a} + {1'b0, b};
            if (lat >= 1 && lat <= TIMEOUT) exp_q.push_back({1'b0, sum[W-1:0]});
            else                            exp_q.push_back({1'b1, {W{1'b0}}});
            iss_q.push_back({a, b});
            lat_q.push_back(lat);
        end
        #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        int w;
        push_req(a, b, lat, w);
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_if.rsp_valid && n < 200);
        check("rsp_valid_arrived", bus_if.rsp_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || bus_if.rsp_valid) && n < 300);
        check("idle_reached", {busy, bus_if.rsp_valid}, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- compute block model ----------------
    // Latency L means dut_valid is high in the L-th cycle after the start cycle; 0 = never.
    initial begin
        logic [W:0] s;
        dut_valid = 1'b0;
        dut_y     = '0;
        forever begin
            @(posedge clk);
            #1;
            dut_valid = 1'b0;
            dut_y     = '0;
            if (!rst_n) begin
                cm_left = 0;
                continue;
            end
            if (spur) begin
                dut_valid = 1'b1;
                dut_y     = 16'hdead;
                spur      = 1'b0;
            end
            if (cm_left > 0) begin
                cm_left--;
                if (cm_left == 0) begin
                    s         = {1'b0, dut_a} + {1'b0, dut_b};
                    dut_valid = 1'b1;
                    dut_y     = s[W-1:0];
                end
            end
            if (dut_start) begin
                if (lat_q.size() == 0) check("model_start_unplanned", dut_start, 0);
                else cm_left = lat_q.pop_front();
            end
        end
    end

    // ---------------- scoreboard / per-cycle compare ----------------
    initial begin
        logic [W-1:0]   prev_y;
        logic           prev_err;
        bit             stalled;
        logic [W:0]     e;
        logic [2*W-1:0] op;
        stalled  = 1'b0;
        prev_y   = '0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            check("busy", busy, exp_q.size() != 0);
            if (stalled) begin
                check("hold_valid", bus_if.rsp_valid, 1);
                check("hold_y", bus_if.rsp_y, prev_y);
                check("hold_err", bus_if.rsp_err, prev_err);
            end
            if (bus_if.rsp_valid && bus_if.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", bus_if.rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_y", bus_if.rsp_y, e[W-1:0]);
                    check("rsp_err", bus_if.rsp_err, e[W]);
                end
                rsp_cnt++;
                last_y   = bus_if.rsp_y;
                last_err = bus_if.rsp_err;
            end
            stalled  = bus_if.rsp_valid && !bus_if.rsp_ready;
            prev_y   = bus_if.rsp_y;
            prev_err = bus_if.rsp_err;
            if (dut_start) begin
                check("start_spacing", (cyc - last_start_cyc) >= 4, 1);
                if (iss_q.size() == 0) begin
                    check("unexpected_start", dut_start, 0);
                end else begin
                    op = iss_q.pop_front();
                    check("dut_a", dut_a, op[2*W-1:W]);
                    check("dut_b", dut_b, op[W-1:0]);
                end
                start_cnt++;
                last_start_cyc = cyc;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int sc;
        int rc;
        int w5;
        rst_n            = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        bus_if.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus_if.req_ready, 0);
        check("rst_rsp_valid", bus_if.rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dut_start", dut_start, 0);
        check("rst_state", fsm_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", bus_if.req_ready, 1);
        @(posedge clk);
        #1;

        // Stray dut_valid while idle must not produce anything.
        spur = 1'b1;
        repeat (4) @(negedge clk);
        check("spur_idle_busy", busy, 0);
        check("spur_idle_rsp", bus_if.rsp_valid, 0);
        @(posedge clk);
        #1;

        // Single request, result two cycles after start.
        sc = start_cnt;
        push(16'd3, 16'd5, 2);
        wait_rsp();
        check("basic_latency", cyc - last_start_cyc, 3);
        check("basic_y", bus_if.rsp_y, 16'd8);
        check("basic_err", bus_if.rsp_err, 0);
        @(posedge clk);
        #1;
        wait_idle();
        check("basic_one_start", start_cnt - sc, 1);

        // Compute block never answers.
        push(16'h1234, 16'h1111, 0);
        wait_rsp();
        check("timeout_latency", cyc - last_start_cyc, 16);
        check("timeout_y", bus_if.rsp_y, 0);
        check("timeout_err", bus_if.rsp_err, 1);
        @(posedge clk);
        #1;
        wait_idle();

        // Answer on the final allowed wait cycle.
        push(16'd100, 16'd23, 15);
        wait_rsp();
        check("edge_latency", cyc - last_start_cyc, 16);
        check("edge_y", bus_if.rsp_y, 16'd123);
        check("edge_err", bus_if.rsp_err, 0);
        @(posedge clk);
        #1;
        wait_idle();

        // One cycle too late: timeout, late valid ignored.
        push(16'd7, 16'd9, 16);
        wait_rsp();
        check("late_err", bus_if.rsp_err, 1);
        @(posedge clk);
        #1;
        wait_idle();
        check("late_last_y", last_y, 0);

        // Downstream stall with a stray valid during HOLD.
        bus_if.rsp_ready = 1'b0;
        push(16'hffff, 16'h0002, 3);
        wait_rsp();
        check("stall_y", bus_if.rsp_y, 16'h0001);
        sc = start_cnt;
        @(posedge clk);
        #1;
        spur = 1'b1;
        repeat (10) @(negedge clk);
        check("stall_no_start", start_cnt - sc, 0);
        check("stall_valid", bus_if.rsp_valid, 1);
        check("stall_y_kept", bus_if.rsp_y, 16'h0001);
        @(posedge clk);
        #1;
        bus_if.rsp_ready = 1'b1;
        wait_idle();
        check("stall_last_y", last_y, 16'h0001);

        // Fill the FIFO behind a held response.
        rc = rsp_cnt;
        bus_if.rsp_ready = 1'b0;
        push(16'd1, 16'd1, 1);
        wait_rsp();
        @(posedge clk);
        #1;
        push(16'd10, 16'd1, 2);
        push(16'd20, 16'd2, 1);
        push(16'd30, 16'd3, 4);
        push(16'd40, 16'd4, 2);
        @(negedge clk);
        check("full_req_ready", bus_if.req_ready, 0);
        @(posedge clk);
        #1;
        fork
            push_req(16'd50, 16'd5, 3, w5);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus_if.rsp_ready = 1'b1;
            end
        join
        check("fifth_waited", w5 > 0, 1);
        wait_idle();
        check("full_rsp_count", rsp_cnt - rc, 6);
        check("full_last_y", last_y, 16'd55);

        // Reset while a transaction waits and two more are queued.
        push(16'd1, 16'd2, 0);
        push(16'd3, 16'd4, 2);
        push(16'd5, 16'd6, 2);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        iss_q.delete();
        lat_q.delete();
        #1;
        check("mid_rst_req_ready", bus_if.req_ready, 0);
        check("mid_rst_rsp_valid", bus_if.rsp_valid, 0);
        check("mid_rst_rsp_err", bus_if.rsp_err, 0);
        check("mid_rst_rsp_y", bus_if.rsp_y, 0);
        check("mid_rst_dut_start", dut_start, 0);
        check("mid_rst_dut_a", dut_a, 0);
        check("mid_rst_dut_b", dut_b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", fsm_state, IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sc = start_cnt;
        rc = rsp_cnt;
        @(negedge clk);
        check("release_no_start", dut_start, 0);
        repeat (30) @(negedge clk);
        check("release_starts", start_cnt - sc, 0);
        check("release_rsps", rsp_cnt - rc, 0);
        check("release_busy", busy, 0);
        @(posedge clk);
        #1;

        // Normal operation after reset.
        push(16'd9, 16'd9, 1);
        wait_idle();
        check("after_rst_y", last_y, 16'd18);
        check("after_rst_err", last_err, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/design_28_driver.md
DESIGN_28_DRIVER -- requirements
Module: design_28_driver

Interface
REQ-001 Parameter W, default 16, operand/result width in bits.
REQ-002 Parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-003 Parameter TIMEOUT, default 15, max cycles waited for dut_valid (1..255).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  upstream request present.
REQ-007 req_ready  output  1  request FIFO can accept.
REQ-008 req_a, req_b  input  W each  request operands.
REQ-009 rsp_valid  output  1  response held for downstream.
REQ-010 rsp_ready  input  1  downstream accepts response.
REQ-011 rsp_y  output  W  result; zero on error.
REQ-012 rsp_err  output  1  response produced by timeout.
REQ-013 dut_start  output  1  one-cycle start pulse to compute block.
REQ-014 dut_a, dut_b  output  W each  operands to compute block.
REQ-015 dut_y  input  W  result from compute block.
REQ-016 dut_valid  input  1  result-valid from compute block.
REQ-017 busy  output  1  high when FSM not IDLE or FIFO not empty.

Function
REQ-018 Request push on req_valid && req_ready; req_ready = !fifo_full (combinational from registered count).
REQ-019 FSM states IDLE, ISSUE, WAIT, HOLD; exactly one transaction outstanding.
REQ-020 IDLE: fifo not empty -> pop head into dut_a/dut_b registers, go ISSUE next cycle.
REQ-021 ISSUE: dut_start=1 for exactly this cycle; counter cleared; go WAIT.
REQ-022 dut_a/dut_b held stable from ISSUE until next pop.
REQ-023 WAIT: counter increments per cycle; dut_valid=1 -> capture dut_y into rsp_y, rsp_err=0, go HOLD.
REQ-024 WAIT: counter reaching TIMEOUT without dut_valid -> rsp_y=0, rsp_err=1, go HOLD.
REQ-025 dut_valid and timeout in same cycle -> dut_valid wins (rsp_err=0).
REQ-026 dut_valid outside WAIT ignored; no state change.
REQ-027 HOLD: rsp_valid=1, rsp_y/rsp_err stable until rsp_ready; on rsp_valid && rsp_ready go IDLE.
REQ-028 Minimum issue-to-issue spacing 4 cycles (HOLD->IDLE->ISSUE); no back-to-back start pulses.
REQ-029 Push while full ignored (req_ready=0); push and pop in same cycle legal when not full, count unchanged.
REQ-030 FIFO pointers wrap modulo DEPTH; responses returned in request order.
REQ-031 Counter width clog2(TIMEOUT+1); saturates, never wraps.

Reset
REQ-032 rst_n low asynchronously: FSM IDLE, FIFO empty, counter 0, dut_a/dut_b 0, rsp_y 0.
REQ-033 Outputs during reset: req_ready=0 while rst_n low, 1 after release; rsp_valid, rsp_err, dut_start, busy all 0.
REQ-034 Reset mid-transaction discards FIFO contents and pending response; no start issued in first cycle after release.

Structure
REQ-035 Shared package holds FSM state enum and default W/DEPTH/TIMEOUT constants.
REQ-036 One sub-module: design_28_req_fifo (synchronous FIFO, width 2*W, depth DEPTH, full/empty/count).
REQ-037 All outputs driven from registers except req_ready.

Verification
REQ-038 Single request a=3,b=5, DUT model valid 2 cycles after start with y=8 -> one start pulse, rsp_y=8, rsp_err=0.
REQ-039 Push 5 requests back-to-back, DEPTH=4 -> req_ready low after 4th accepted, 5th accepted after first pop; 5 responses in order.
REQ-040 DUT never asserts valid -> rsp_valid after TIMEOUT=15 WAIT cycles, rsp_y=0, rsp_err=1.
REQ-041 dut_valid on exactly the 15th WAIT cycle -> rsp_err=0, rsp_y=dut_y.
REQ-042 rsp_ready held low 10 cycles -> rsp_valid, rsp_y stable, no new dut_start.
REQ-043 rst_n low during WAIT with 2 queued -> all outputs zero, no responses after release.
